// File: rtl/rr_grant_encoder.sv
// Four-way round-robin request encoder; registered 2-bit grant index with valid/ready offer.
// Latency: nonzero req sampled in IDLE gives gnt_vld one edge later; one accept per cycle sustained.
// Backpressure: offer is sticky while gnt_rdy=0. Optional RR_ENC_LOCK_EN adds gnt_lock/LOCK state.
module rr_grant_encoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    output logic [1:0]       gnt_idx,
    output logic             gnt_vld,
    input  logic             gnt_rdy,
    output logic [CNT_W-1:0] gnt_cnt,
`ifdef RR_ENC_LOCK_EN
    input  logic             gnt_lock,
`endif
    output logic             idle
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OFFER = 2'd1,
        S_LOCK  = 2'd2
    } state_t;

    state_t           r_state;
    logic [1:0]       r_ptr;
    logic [1:0]       r_gnt_idx;
    logic             r_gnt_vld;
    logic [CNT_W-1:0] r_gnt_cnt;
    logic             r_idle;

    logic [2:0]       w_win_ptr;
    logic [2:0]       w_win_nxt;
    logic [1:0]       w_nxt_ptr;

    // Returns {found, index}: first set bit of r scanning from p upward, modulo 4.
    function automatic logic [2:0] f_arb(input logic [3:0] r, input logic [1:0] p);
        logic [3:0] rot;
        logic [1:0] k;
        logic       found;
        rot   = r;
        k     = 2'd0;
        found = 1'b1;
        case (p)
            2'd0:    rot = r;
            2'd1:    rot = {r[0], r[3:1]};
            2'd2:    rot = {r[1:0], r[3:2]};
            2'd3:    rot = {r[2:0], r[3]};
            default: rot = r;
        endcase
        casez (rot)
            4'b???1: k = 2'd0;
            4'b??10: k = 2'd1;
            4'b?100: k = 2'd2;
            4'b1000: k = 2'd3;
            default: found = 1'b0;
        endcase
        return {found, p + k};
    endfunction

    assign w_nxt_ptr = r_gnt_idx + 2'd1;
    assign w_win_ptr = f_arb(req, r_ptr);
    assign w_win_nxt = f_arb(req, w_nxt_ptr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ptr     <= 2'd0;
            r_gnt_idx <= 2'd0;
            r_gnt_vld <= 1'b0;
            r_gnt_cnt <= '0;
            r_idle    <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_win_ptr[2]) begin
                        r_gnt_idx <= w_win_ptr[1:0];
                        r_gnt_vld <= 1'b1;
                        r_idle    <= 1'b0;
                        r_state   <= S_OFFER;
                    end else begin
                        r_gnt_vld <= 1'b0;
                        r_idle    <= 1'b1;
                    end
                end
                S_OFFER: begin
                    r_gnt_vld <= 1'b1;
                    r_idle    <= 1'b0;
                    if (gnt_rdy) begin
                        r_ptr     <= w_nxt_ptr;
                        r_gnt_cnt <= r_gnt_cnt + CNT_W'(1);
`ifdef RR_ENC_LOCK_EN
                        if (gnt_lock) begin
                            r_gnt_vld <= 1'b0;
                            r_state   <= S_LOCK;
                        end else
`endif
                        if (w_win_nxt[2]) begin
                            r_gnt_idx <= w_win_nxt[1:0];
                        end else begin
                            r_gnt_vld <= 1'b0;
                            r_idle    <= 1'b1;
                            r_state   <= S_IDLE;
                        end
                    end
                end
`ifdef RR_ENC_LOCK_EN
                S_LOCK: begin
                    r_gnt_vld <= 1'b0;
                    r_idle    <= 1'b0;
                    if (!gnt_lock) begin
                        r_idle  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
`endif
                default: begin
                    r_gnt_vld <= 1'b0;
                    r_idle    <= 1'b1;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt_idx = r_gnt_idx;
    assign gnt_vld = r_gnt_vld;
    assign gnt_cnt = r_gnt_cnt;
    assign idle    = r_idle;

endmodule
